// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants and helpers for the sprite layer arbiter.
//   COLOR_W : width of one {R,G,B} colour word
//   BLACK   : colour driven while video is off
//   clog2() : index width for a given layer count (minimum 1 bit)
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] BLACK = 12'h000;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// ---------------------------------------------------------------------------
// layer_priority_enc
// Combinational lowest-index-wins encoder over a layer visibility vector.
// Ports:
//   visible      in  NUM_LAYERS  per-layer visible flag (bit 0 = top layer)
//   index        out IDX_W       index of the lowest-numbered visible layer
//   anyVisible   out 1           at least one layer visible
//   multiVisible out 1           two or more layers visible
// index is 0 when nothing is visible; qualify it with anyVisible.
// ---------------------------------------------------------------------------
module layer_priority_enc
  import arb_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] visible,
  output logic [IDX_W-1:0]      index,
  output logic                  anyVisible,
  output logic                  multiVisible
);

  always_comb begin
    index        = '0;
    anyVisible   = 1'b0;
    multiVisible = 1'b0;
    // Walk from the bottom layer up so the lowest index is written last.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (visible[i]) begin
        index = IDX_W'(i);
      end
    end
    // Second hit on the way up means two or more layers are visible.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (visible[i]) begin
        if (anyVisible) multiVisible = 1'b1;
        anyVisible = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_layer_arbiter
// Per-pixel priority arbiter between the world-map background and
// NUM_LAYERS sprite layers feeding the Colorizer. Two-cycle pipeline; DTG
// timing is delayed alongside the colour. Also owns frame-synchronous layer
// enables, frame-rate blinking and a per-frame sprite overlap flag.
// Ports:
//   pClk          in   pixel clock
//   pReset        in   synchronous active-high reset
//   pWorld        in   background colour
//   pLayer_pix    in   sprite colours, layer i at [12i+11:12i]
//   pLayer_opq    in   per-layer opaque flags
//   pVideo_on_in  in   DTG video_on
//   pHsync_in     in   DTG hsync
//   pVsync_in     in   DTG vsync
//   pCfg_we       in   config write strobe (loads shadow masks)
//   pCfg_en       in   layer enable mask
//   pCfg_blink    in   layer blink mask
//   pIcon         out  arbitrated colour
//   pVideo_on     out  delayed video_on
//   pHsync        out  delayed hsync
//   pVsync        out  delayed vsync
//   pCollision    out  previous frame had a sprite/sprite overlap
//   pFrame_tick   out  one-cycle pulse at frame start, aligned with pVsync
// ---------------------------------------------------------------------------
module sprite_layer_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_LAYERS       = 4,
  parameter int BLINK_FRAMES     = 16,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic                          pClk,
  input  logic                          pReset,
  input  logic [COLOR_W-1:0]            pWorld,
  input  logic [COLOR_W*NUM_LAYERS-1:0] pLayer_pix,
  input  logic [NUM_LAYERS-1:0]         pLayer_opq,
  input  logic                          pVideo_on_in,
  input  logic                          pHsync_in,
  input  logic                          pVsync_in,
  input  logic                          pCfg_we,
  input  logic [NUM_LAYERS-1:0]         pCfg_en,
  input  logic [NUM_LAYERS-1:0]         pCfg_blink,
  output logic [COLOR_W-1:0]            pIcon,
  output logic                          pVideo_on,
  output logic                          pHsync,
  output logic                          pVsync,
  output logic                          pCollision,
  output logic                          pFrame_tick
);

  localparam int         IDX_W      = clog2(NUM_LAYERS);
  // Both syncs share the vsync polarity; this is their idle level.
  localparam logic       SYNC_IDLE  = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // Stage 1
  logic [COLOR_W-1:0]            s1World;
  logic [COLOR_W*NUM_LAYERS-1:0] s1Pix;
  logic [NUM_LAYERS-1:0]         s1Opq;
  logic                          s1VideoOn;
  logic                          s1Hsync;
  logic                          s1Vsync;

  // Frame / config state
  logic [NUM_LAYERS-1:0] activeEn;
  logic [NUM_LAYERS-1:0] shadowEn;
  logic [NUM_LAYERS-1:0] activeBlink;
  logic [NUM_LAYERS-1:0] shadowBlink;
  logic [7:0]            blinkCnt;
  logic                  blinkPhase;
  logic                  vsyncActPrev;
  logic                  overlapSticky;

  logic                  s1VsyncAct;
  logic                  frameStart;
  logic [NUM_LAYERS-1:0] blinkShow;
  logic [NUM_LAYERS-1:0] visSel;
  logic [NUM_LAYERS-1:0] visCol;

  logic [IDX_W-1:0]      selIdx;
  logic                  selAny;
  logic                  selMulti;
  logic [IDX_W-1:0]      colIdx;
  logic                  colAny;
  logic                  colMulti;
  logic                  unusedEnc;

  logic [COLOR_W-1:0]    layerColor;
  logic [COLOR_W-1:0]    nextIcon;

  always_ff @(posedge pClk) begin
    if (pReset) begin
      s1World   <= '0;
      s1Pix     <= '0;
      s1Opq     <= '0;
      s1VideoOn <= 1'b0;
      s1Hsync   <= SYNC_IDLE;
      s1Vsync   <= SYNC_IDLE;
    end else begin
      s1World   <= pWorld;
      s1Pix     <= pLayer_pix;
      s1Opq     <= pLayer_opq;
      s1VideoOn <= pVideo_on_in;
      s1Hsync   <= pHsync_in;
      s1Vsync   <= pVsync_in;
    end
  end

  assign s1VsyncAct = (VSYNC_ACTIVE_LOW != 0) ? ~s1Vsync : s1Vsync;
  assign frameStart = s1VsyncAct & ~vsyncActPrev;

  // Blink only hides a layer from display; overlap detection ignores it so
  // a blinking sprite still registers hits.
  assign blinkShow = ~activeBlink | {NUM_LAYERS{blinkPhase}};
  assign visSel    = s1Opq & activeEn & blinkShow;
  assign visCol    = s1Opq & activeEn;

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) uSelEnc (
    .visible      (visSel),
    .index        (selIdx),
    .anyVisible   (selAny),
    .multiVisible (selMulti)
  );

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) uColEnc (
    .visible      (visCol),
    .index        (colIdx),
    .anyVisible   (colAny),
    .multiVisible (colMulti)
  );

  assign unusedEnc = ^{selMulti, colAny, colIdx};

  always_comb begin
    layerColor = s1World;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (selIdx == IDX_W'(i)) begin
        layerColor = s1Pix[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_comb begin
    nextIcon = BLACK;
    if (s1VideoOn) begin
      nextIcon = selAny ? layerColor : s1World;
    end
  end

  // Stage 2
  always_ff @(posedge pClk) begin
    if (pReset) begin
      pIcon       <= BLACK;
      pVideo_on   <= 1'b0;
      pHsync      <= SYNC_IDLE;
      pVsync      <= SYNC_IDLE;
      pFrame_tick <= 1'b0;
    end else begin
      pIcon       <= nextIcon;
      pVideo_on   <= s1VideoOn;
      pHsync      <= s1Hsync;
      pVsync      <= s1Vsync;
      pFrame_tick <= frameStart;
    end
  end

  // Masks, blink timing and overlap reporting all advance on frame start.
  // A config write in the frame-start cycle lands in the shadow only; the
  // active copy takes the pre-write shadow through non-blocking semantics.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      activeEn      <= '1;
      shadowEn      <= '1;
      activeBlink   <= '0;
      shadowBlink   <= '0;
      blinkCnt      <= '0;
      blinkPhase    <= 1'b1;
      vsyncActPrev  <= 1'b0;
      overlapSticky <= 1'b0;
      pCollision    <= 1'b0;
    end else begin
      vsyncActPrev <= s1VsyncAct;

      if (pCfg_we) begin
        shadowEn    <= pCfg_en;
        shadowBlink <= pCfg_blink;
      end

      if (frameStart) begin
        activeEn      <= shadowEn;
        activeBlink   <= shadowBlink;
        pCollision    <= overlapSticky;
        overlapSticky <= 1'b0;
        if (blinkCnt == BLINK_LAST) begin
          blinkCnt   <= '0;
          blinkPhase <= ~blinkPhase;
        end else begin
          blinkCnt <= blinkCnt + 8'd1;
        end
      end else if (s1VideoOn && colMulti) begin
        overlapSticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
module tb_sprite_layer_arbiter;
  import arb_pkg::*;

  localparam int NL = 4;

  logic                     pClk = 1'b0;
  logic                     pReset;
  logic [COLOR_W-1:0]       pWorld;
  logic [COLOR_W*NL-1:0]    pLayer_pix;
  logic [NL-1:0]            pLayer_opq;
  logic                     pVideo_on_in;
  logic                     pHsync_in;
  logic                     pVsync_in;
  logic                     pCfg_we;
  logic [NL-1:0]            pCfg_en;
  logic [NL-1:0]            pCfg_blink;
  logic [COLOR_W-1:0]       pIcon;
  logic                     pVideo_on;
  logic                     pHsync;
  logic                     pVsync;
  logic                     pCollision;
  logic                     pFrame_tick;

  int testsRun    = 0;
  int testsFailed = 0;

  sprite_layer_arbiter #(
    .NUM_LAYERS       (NL),
    .BLINK_FRAMES     (2),
    .VSYNC_ACTIVE_LOW (1)
  ) dut (
    .pClk         (pClk),
    .pReset       (pReset),
    .pWorld       (pWorld),
    .pLayer_pix   (pLayer_pix),
    .pLayer_opq   (pLayer_opq),
    .pVideo_on_in (pVideo_on_in),
    .pHsync_in    (pHsync_in),
    .pVsync_in    (pVsync_in),
    .pCfg_we      (pCfg_we),
    .pCfg_en      (pCfg_en),
    .pCfg_blink   (pCfg_blink),
    .pIcon        (pIcon),
    .pVideo_on    (pVideo_on),
    .pHsync       (pHsync),
    .pVsync       (pVsync),
    .pCollision   (pCollision),
    .pFrame_tick  (pFrame_tick)
  );

  always #5 pClk = ~pClk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pClk);
      #1;
    end
  endtask

  // Vsync pulse (active low) with video blanked; checks the frame tick.
  task automatic pulseVsync();
    pVideo_on_in = 1'b0;
    pVsync_in    = 1'b0;
    tick(2);
    checkEq("frameTick", pFrame_tick, 1);
    checkEq("vsyncOut", pVsync, 0);
    tick(1);
    checkEq("frameTickEnd", pFrame_tick, 0);
    pVsync_in = 1'b1;
    tick(2);
  endtask

  logic [2:0] syncPat [8];

  initial begin
    syncPat[0] = 3'b110; syncPat[1] = 3'b100; syncPat[2] = 3'b011; syncPat[3] = 3'b001;
    syncPat[4] = 3'b111; syncPat[5] = 3'b010; syncPat[6] = 3'b101; syncPat[7] = 3'b110;

    pReset       = 1'b1;
    pWorld       = 12'hABC;
    pLayer_pix   = '0;
    pLayer_opq   = '0;
    pVideo_on_in = 1'b1;
    pHsync_in    = 1'b1;
    pVsync_in    = 1'b1;
    pCfg_we      = 1'b0;
    pCfg_en      = 4'hF;
    pCfg_blink   = 4'h0;
    tick(3);
    checkEq("rstIcon", pIcon, 12'h000);
    checkEq("rstVideoOn", pVideo_on, 0);
    checkEq("rstHsync", pHsync, 1);
    checkEq("rstVsync", pVsync, 1);
    checkEq("rstCollision", pCollision, 0);
    checkEq("rstFrameTick", pFrame_tick, 0);

    // Background only, two-cycle latency
    pReset = 1'b0;
    tick(1);
    checkEq("latencyCycle1", pIcon, 12'h000);
    tick(1);
    checkEq("worldIcon", pIcon, 12'hABC);
    checkEq("worldVideoOn", pVideo_on, 1);

    // Layers 1 and 3 overlapping
    pLayer_pix = {12'h0F0, 12'h000, 12'hF00, 12'h000};
    pLayer_opq = 4'b1010;
    tick(2);
    checkEq("prioL1", pIcon, 12'hF00);
    tick(4);
    checkEq("collBeforeFs", pCollision, 0);
    pulseVsync();
    checkEq("collAfterFs", pCollision, 1);
    pLayer_opq   = 4'b0010;
    pVideo_on_in = 1'b1;
    tick(4);
    checkEq("cleanFrameIcon", pIcon, 12'hF00);
    checkEq("collHeld", pCollision, 1);
    pulseVsync();
    checkEq("collCleared", pCollision, 0);

    // Sync/video_on delay with layer 0 opaque
    pLayer_pix = {12'h000, 12'h000, 12'h000, 12'hFFF};
    pLayer_opq = 4'b0001;
    {pVsync_in, pHsync_in, pVideo_on_in} = syncPat[0];
    tick(1);
    for (int i = 1; i < 8; i++) begin
      {pVsync_in, pHsync_in, pVideo_on_in} = syncPat[i];
      tick(1);
      checkEq("dlyVsync", pVsync, syncPat[i-1][2]);
      checkEq("dlyHsync", pHsync, syncPat[i-1][1]);
      checkEq("dlyVideoOn", pVideo_on, syncPat[i-1][0]);
      checkEq("dlyIcon", pIcon, syncPat[i-1][0] ? 12'hFFF : 12'h000);
    end
    pVsync_in = 1'b1;
    pHsync_in = 1'b1;
    tick(2);

    // Enable mask written mid-frame
    pWorld       = 12'h111;
    pLayer_pix   = {12'h000, 12'h000, 12'h000, 12'h00F};
    pLayer_opq   = 4'b0001;
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("enBefore", pIcon, 12'h00F);
    pCfg_we = 1'b1;
    pCfg_en = 4'b1110;
    tick(1);
    pCfg_we = 1'b0;
    tick(3);
    checkEq("enMidFrame", pIcon, 12'h00F);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("enApplied", pIcon, 12'h111);

    // Reset mid-frame with an overlap pending
    pLayer_pix = {12'h000, 12'h0F0, 12'hF00, 12'h00F};
    pLayer_opq = 4'b0111;
    tick(2);
    checkEq("l0Disabled", pIcon, 12'hF00);
    tick(2);
    pReset = 1'b1;
    tick(2);
    checkEq("midRstIcon", pIcon, 12'h000);
    pReset     = 1'b0;
    pLayer_opq = 4'b0001;
    tick(2);
    checkEq("rstEnAllOnes", pIcon, 12'h00F);
    pulseVsync();
    checkEq("rstNoCollision", pCollision, 0);

    // Config write coincident with frame start
    pVideo_on_in = 1'b0;
    pVsync_in    = 1'b0;
    tick(1);
    pCfg_we = 1'b1;
    pCfg_en = 4'b1110;
    tick(1);
    pCfg_we = 1'b0;
    checkEq("coincidentTick", pFrame_tick, 1);
    tick(1);
    pVsync_in = 1'b1;
    tick(2);
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("cfgAtFsOld", pIcon, 12'h00F);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("cfgAtFsNext", pIcon, 12'h111);

    // Blink with BLINK_FRAMES = 2
    pReset = 1'b1;
    tick(2);
    pReset     = 1'b0;
    pCfg_we    = 1'b1;
    pCfg_en    = 4'b1111;
    pCfg_blink = 4'b0001;
    tick(1);
    pCfg_we      = 1'b0;
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF0", pIcon, 12'h00F);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF1", pIcon, 12'h00F);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF2", pIcon, 12'h111);
    pLayer_opq = 4'b0011;
    tick(2);
    checkEq("blinkHiddenL1", pIcon, 12'hF00);
    pulseVsync();
    checkEq("blinkCollide", pCollision, 1);
    pLayer_opq   = 4'b0001;
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF3", pIcon, 12'h111);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF4", pIcon, 12'h00F);
    checkEq("blinkCollClear", pCollision, 0);
    pulseVsync();
    pVideo_on_in = 1'b1;
    tick(2);
    checkEq("blinkF5", pIcon, 12'h00F);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
